// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter that lets NREQ packet sources share one FIFO write port.
// A requester owns the port from the edge it is granted until its LAST beat is
// accepted. At least one IDLE cycle separates packets. Each FIFO word carries
// the source ID and the end-of-packet flag next to the payload.
//
// Parameters
//   WIDTH      payload width per requester
//   NREQ       number of requesters (2..8)
//   IDW        source-ID width, must equal $clog2(NREQ)
//   MAX_BEATS  beats allowed per packet before OVERRUN is flagged
//
// Ports
//   WCLK      in   write-domain clock
//   WRESETn   in   asynchronous active-low reset
//   S_DATA    in   requester payloads, requester i at [i*WIDTH +: WIDTH]
//   S_LAST    in   per-requester end-of-packet marker
//   S_VALID   in   per-requester valid
//   S_READY   out  per-requester ready (only the owner's bit can be high)
//   WDATA     out  FIFO write word {id, last, payload}
//   WVALID    out  FIFO write valid
//   WREADY    in   FIFO write ready (FIFO not full)
//   GRANT_ID  out  requester granted most recently
//   BUSY      out  high while a packet is owned
//   OVERRUN   out  sticky flag: a packet ran past MAX_BEATS
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int MAX_BEATS = 256
) (
  input  logic                    WCLK,
  input  logic                    WRESETn,
  input  logic [NREQ*WIDTH-1:0]   S_DATA,
  input  logic [NREQ-1:0]         S_LAST,
  input  logic [NREQ-1:0]         S_VALID,
  output logic [NREQ-1:0]         S_READY,
  output logic [WIDTH+IDW:0]      WDATA,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic [IDW-1:0]          GRANT_ID,
  output logic                    BUSY,
  output logic                    OVERRUN
);

  // Counter wide enough to hold MAX_BEATS itself, where it saturates.
  localparam int BCW = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   r_ptr;
  logic [BCW-1:0]   r_bcnt;
  logic             r_busy;
  logic             r_overrun;

  logic             w_found;
  logic [IDW-1:0]   w_sel;
  logic [IDW-1:0]   w_idx;
  logic [WIDTH-1:0] w_payload;
  logic             w_last;
  logic             w_beat;

  // Round-robin search starting at r_ptr. Scanning from the farthest offset
  // down to zero lets the nearest valid requester overwrite earlier hits.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_idx   = r_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = IDW'((int'(r_ptr) + i) % NREQ);
      if (S_VALID[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Payload mux for the current owner; constant slices keep the select simple.
  always_comb begin
    w_payload = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == r_grant) begin
        w_payload = S_DATA[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_last = S_LAST[r_grant];

  // Handshake path is purely combinational so the owner streams at full rate.
  always_comb begin
    S_READY = '0;
    WVALID  = 1'b0;
    if (r_state == ST_OWN) begin
      WVALID           = S_VALID[r_grant];
      S_READY[r_grant] = WREADY;
    end
  end

  assign w_beat   = WVALID & WREADY;
  assign WDATA    = {r_grant, w_last, w_payload};
  assign GRANT_ID = r_grant;
  assign BUSY     = r_busy;
  assign OVERRUN  = r_overrun;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever order the statements are written in.
  always_ff @(posedge WCLK or negedge WRESETn) begin
    if (!WRESETn) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_bcnt    <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_OWN;
            r_grant <= w_sel;
            r_busy  <= 1'b1;
            r_bcnt  <= '0;
          end
        end
        ST_OWN: begin
          if (w_beat) begin
            // Flag the beat that starts past the limit; the packet still runs
            // to completion.
            if (r_bcnt == BCW'(MAX_BEATS - 1) && !w_last) begin
              r_overrun <= 1'b1;
            end
            if (r_bcnt != BCW'(MAX_BEATS)) begin
              r_bcnt <= r_bcnt + 1'b1;
            end
            // Packet end: release the port and move priority past the owner.
            // No new grant on this edge, which forces one IDLE cycle.
            if (w_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_ptr   <= (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Bench for fifo_write_arbiter with NREQ=4, WIDTH=16 and MAX_BEATS=4. A small
// MAX_BEATS makes overruns reachable in short packets. Inputs change 1 ns after
// the rising edge and outputs are sampled 1 ns after that.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int ID = 2;
  localparam int MB = 4;

  logic              WCLK = 1'b0;
  logic              WRESETn;
  logic [N*W-1:0]    S_DATA;
  logic [N-1:0]      S_LAST;
  logic [N-1:0]      S_VALID;
  logic [N-1:0]      S_READY;
  logic [W+ID:0]     WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [ID-1:0]     GRANT_ID;
  logic              BUSY;
  logic              OVERRUN;

  fifo_write_arbiter #(
    .WIDTH(W), .NREQ(N), .IDW(ID), .MAX_BEATS(MB)
  ) dut (
    .WCLK(WCLK), .WRESETn(WRESETn), .S_DATA(S_DATA), .S_LAST(S_LAST),
    .S_VALID(S_VALID), .S_READY(S_READY), .WDATA(WDATA), .WVALID(WVALID),
    .WREADY(WREADY), .GRANT_ID(GRANT_ID), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 WCLK = ~WCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owner -1 means nobody owns the port.
  int m_owner;
  int m_ptr;
  int m_bcnt;
  int m_grant;
  bit m_ovr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge WCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_bcnt  = 0;
    m_grant = 0;
    m_ovr   = 1'b0;
  endtask

  task automatic do_reset();
    WRESETn = 1'b0;
    S_VALID = '0;
    S_LAST  = '0;
    WREADY  = 1'b0;
    S_DATA  = '0;
    model_reset();
    next_cycle();
    next_cycle();
    WRESETn = 1'b1;
  endtask

  task automatic set_payload(input int req, input logic [W-1:0] val);
    S_DATA[req*W +: W] = val;
  endtask

  // Expected outputs derived from the model for the inputs currently driven.
  task automatic model_check(input int cyc);
    logic             exp_wvalid;
    logic [N-1:0]     exp_ready;
    logic [W+ID:0]    exp_wdata;
    exp_wvalid = 1'b0;
    exp_ready  = '0;
    exp_wdata  = '0;
    if (m_owner >= 0) begin
      exp_wvalid = S_VALID[m_owner];
      exp_ready  = N'(WREADY) << m_owner;
      exp_wdata  = {ID'(m_owner), S_LAST[m_owner], S_DATA[m_owner*W +: W]};
    end
    check($sformatf("rnd%0d wvalid", cyc), WVALID, exp_wvalid);
    check($sformatf("rnd%0d s_ready", cyc), S_READY, exp_ready);
    check($sformatf("rnd%0d busy", cyc), BUSY, (m_owner >= 0));
    check($sformatf("rnd%0d grant", cyc), GRANT_ID, m_grant);
    check($sformatf("rnd%0d overrun", cyc), OVERRUN, m_ovr);
    if (exp_wvalid) check($sformatf("rnd%0d wdata", cyc), WDATA, exp_wdata);
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    int best;
    int bestd;
    int d;
    if (m_owner < 0) begin
      best  = -1;
      bestd = N;
      for (int r = 0; r < N; r++) begin
        d = (r - m_ptr + N) % N;
        if (S_VALID[r] && d < bestd) begin
          bestd = d;
          best  = r;
        end
      end
      if (best >= 0) begin
        m_owner = best;
        m_grant = best;
        m_bcnt  = 0;
      end
    end else if (S_VALID[m_owner] && WREADY) begin
      // m_bcnt counts beats already delivered in this packet.
      if (m_bcnt == MB - 1 && !S_LAST[m_owner]) m_ovr = 1'b1;
      if (m_bcnt < MB) m_bcnt++;
      if (S_LAST[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic         wready;
    logic         busy;
    logic         chk_grant;
    logic [ID-1:0] grant;
    logic         wvalid;
    logic [N-1:0] ready;
    logic         wlast;
  } vec_t;

  vec_t tbl[$];

  initial begin
    WRESETn = 1'b0;
    S_VALID = '0;
    S_LAST  = '0;
    WREADY  = 1'b0;
    S_DATA  = '0;
    model_reset();

    // ---- Table: single requester, then four-way round robin ----
    //            rst   valid    last     wr    busy  chkg  grant  wv    ready    wlast
    tbl.push_back('{1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0});
    tbl.push_back('{1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1});
    tbl.push_back('{1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1});

    foreach (tbl[k]) begin
      if (tbl[k].rst) begin
        do_reset();
        settle();
        check($sformatf("tbl%0d reset overrun", k), OVERRUN, 1'b0);
        check($sformatf("tbl%0d reset grant", k), GRANT_ID, 2'd0);
      end
      S_VALID = tbl[k].valid;
      S_LAST  = tbl[k].last;
      WREADY  = tbl[k].wready;
      for (int r = 0; r < N; r++) set_payload(r, W'(16'hA000 + r));
      settle();
      check($sformatf("tbl%0d busy", k), BUSY, tbl[k].busy);
      check($sformatf("tbl%0d wvalid", k), WVALID, tbl[k].wvalid);
      check($sformatf("tbl%0d s_ready", k), S_READY, tbl[k].ready);
      if (tbl[k].chk_grant) check($sformatf("tbl%0d grant", k), GRANT_ID, tbl[k].grant);
      if (tbl[k].wvalid) check($sformatf("tbl%0d wdata_last", k), WDATA[W], tbl[k].wlast);
      next_cycle();
    end

    // ---- WREADY stall mid-packet: requester 0, 4 beats ----
    do_reset();
    S_VALID = 4'b0001;
    S_LAST  = 4'b0000;
    WREADY  = 1'b1;
    set_payload(0, 16'h1001);
    next_cycle();                       // grant edge
    settle();
    check("stall beat1 s_ready", S_READY, 4'b0001);
    next_cycle();                       // beat 1 accepted
    set_payload(0, 16'h1002);
    WREADY = 1'b0;
    for (int s = 0; s < 5; s++) begin
      settle();
      check($sformatf("stall%0d wvalid", s), WVALID, 1'b1);
      check($sformatf("stall%0d s_ready", s), S_READY, 4'b0000);
      check($sformatf("stall%0d wdata", s), WDATA, {2'd0, 1'b0, 16'h1002});
      check($sformatf("stall%0d busy", s), BUSY, 1'b1);
      next_cycle();
    end
    WREADY = 1'b1;
    settle();
    check("stall release s_ready", S_READY, 4'b0001);
    next_cycle();                       // beat 2
    set_payload(0, 16'h1003);
    next_cycle();                       // beat 3
    set_payload(0, 16'h1004);
    S_LAST = 4'b0001;
    settle();
    check("stall beat4 wdata", WDATA, {2'd0, 1'b1, 16'h1004});
    next_cycle();                       // beat 4, end of packet
    S_VALID = '0;
    S_LAST  = '0;
    settle();
    check("stall end busy", BUSY, 1'b0);
    check("stall end overrun", OVERRUN, 1'b0);

    // ---- Requester 2 owns while requester 0 waits ----
    do_reset();
    S_VALID = 4'b0010;
    S_LAST  = 4'b0010;
    WREADY  = 1'b1;
    next_cycle();                       // grant 1
    next_cycle();                       // 1-beat packet, PTR -> 2
    S_VALID = 4'b0101;
    S_LAST  = 4'b0000;
    settle();
    check("r2 idle busy", BUSY, 1'b0);
    next_cycle();                       // grant 2
    for (int b = 0; b < 3; b++) begin
      S_LAST = (b == 2) ? 4'b0100 : 4'b0000;
      settle();
      check($sformatf("r2 beat%0d grant", b), GRANT_ID, 2'd2);
      check($sformatf("r2 beat%0d s_ready", b), S_READY, 4'b0100);
      next_cycle();
    end
    S_LAST = 4'b0000;
    settle();
    check("r2 gap busy", BUSY, 1'b0);
    check("r2 gap s_ready", S_READY, 4'b0000);
    next_cycle();
    settle();
    check("r2 next grant", GRANT_ID, 2'd0);
    check("r2 next s_ready", S_READY, 4'b0001);

    // ---- Overrun: 6-beat packet with MAX_BEATS=4 ----
    do_reset();
    S_VALID = 4'b0001;
    S_LAST  = 4'b0000;
    WREADY  = 1'b1;
    next_cycle();                       // grant 0
    for (int b = 1; b <= 6; b++) begin
      set_payload(0, W'(16'h6000 + b));
      S_LAST = (b == 6) ? 4'b0001 : 4'b0000;
      settle();
      check($sformatf("ovr beat%0d wdata", b), WDATA, {2'd0, (b == 6), W'(16'h6000 + b)});
      check($sformatf("ovr beat%0d wvalid", b), WVALID, 1'b1);
      check($sformatf("ovr beat%0d overrun", b), OVERRUN, (b >= 5));
      next_cycle();
    end
    S_VALID = '0;
    S_LAST  = '0;
    settle();
    check("ovr end busy", BUSY, 1'b0);
    check("ovr sticky", OVERRUN, 1'b1);

    // ---- Reset during beat 2 ----
    do_reset();
    S_VALID = 4'b0100;
    S_LAST  = 4'b0100;
    WREADY  = 1'b1;
    next_cycle();                       // grant 2
    next_cycle();                       // 1-beat packet, PTR -> 3
    S_VALID = 4'b1001;
    S_LAST  = 4'b0000;
    next_cycle();                       // grant 3
    settle();
    check("rst grant3", GRANT_ID, 2'd3);
    next_cycle();                       // beat 1
    settle();
    check("rst beat2 busy", BUSY, 1'b1);
    WRESETn = 1'b0;
    model_reset();
    #1;
    check("rst async wvalid", WVALID, 1'b0);
    check("rst async busy", BUSY, 1'b0);
    check("rst async s_ready", S_READY, 4'b0000);
    check("rst async grant", GRANT_ID, 2'd0);
    check("rst async overrun", OVERRUN, 1'b0);
    next_cycle();
    WRESETn = 1'b1;
    next_cycle();                       // arbitration from PTR=0
    settle();
    check("rst rearb grant", GRANT_ID, 2'd0);
    check("rst rearb s_ready", S_READY, 4'b0001);

    // ---- Randomized run against the reference model ----
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 150 == 149) do_reset();
      S_VALID = N'($urandom_range(0, 15));
      S_LAST  = N'($urandom & $urandom);
      WREADY  = ($urandom_range(0, 3) != 0);
      S_DATA  = {$urandom, $urandom};
      settle();
      model_check(cyc);
      model_step();
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
